btb_update_ctrl: RTL

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/rv32i_types.sv | 25 ++
 rtl/btb_upd_fifo.sv | 57 +++++
 rtl/btb_update_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the BTB/BHT update path.
package rv32i_types;

    localparam int BTB_ENTRIES = 16;
    localparam int BTB_IDX_W   = 4;

    // One resolved control-flow instruction waiting to be written into the BTB/BHT.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        is_br;
        logic        taken;
    } btb_upd_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } btb_state_e;

    // Word-aligned PC bits select the entry.
    function automatic logic [BTB_IDX_W-1:0] btb_index(input logic [31:0] pc);
        return pc[BTB_IDX_W+1:2];
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Resolved-update queue: power-of-two depth, wrapping pointers, registered
// occupancy count so full/empty never depend on this cycle's pop.
module btb_upd_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  btb_upd_t push_data,
    input  logic     pop,
    output btb_upd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    btb_upd_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointer and count bookkeeping; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB/BHT update controller: invalidates all entries after reset or flush,
// then drains resolved branch/jump updates into the arrays in order.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | walking index 0..ENTRIES-1, invalidating BTB and BHT entries
//   RUN   | popping one queued update per cycle into the arrays
module btb_update_ctrl
    import rv32i_types::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ENTRIES    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [31:0]          upd_target,
    input  logic                 upd_is_br,
    input  logic                 upd_taken,
    input  logic                 flush_req,
    output logic                 upd_ready,
    output logic                 btb_wr_en,
    output logic [BTB_IDX_W-1:0] btb_wr_index,
    output logic [31:0]          btb_wr_tag,
    output logic [31:0]          btb_wr_target,
    output logic                 btb_wr_valid,
    output logic                 bht_wr_en,
    output logic [BTB_IDX_W-1:0] bht_wr_index,
    output logic                 bht_wr_taken,
    output logic                 bht_clr,
    output logic                 busy
);

    localparam logic [BTB_IDX_W-1:0] LAST_IDX = BTB_IDX_W'(ENTRIES - 1);

    btb_state_e           state;
    btb_state_e           next_state;
    logic [BTB_IDX_W-1:0] clr_cnt;
    logic                 clr_last;
    btb_upd_t             push_data;
    btb_upd_t             head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    assign clr_last  = (clr_cnt == LAST_IDX);
    // Ready depends only on registered state plus flush, never on the pop.
    assign upd_ready = !rst && (state == ST_RUN) && !fifo_full && !flush_req;
    // A flush cycle writes nothing so the queued entries are truly discarded.
    assign pop       = !rst && (state == ST_RUN) && !fifo_empty && !flush_req;
    assign busy      = rst || (state == ST_CLEAR) || !fifo_empty;

    assign push_data = '{pc: upd_pc, target: upd_target, is_br: upd_is_br, taken: upd_taken};

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_req),
        .push      (upd_valid && upd_ready),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else     state <= next_state;
    end

    // Clear-walk counter: restarts on reset/flush, idles at 0 outside CLEAR.
    always_ff @(posedge clk) begin
        if (rst || flush_req || state != ST_CLEAR || clr_last) clr_cnt <= '0;
        else                                                   clr_cnt <= clr_cnt + 1'b1;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (!flush_req && clr_last) next_state = ST_RUN;
            ST_RUN:   if (flush_req)              next_state = ST_CLEAR;
            default:                              next_state = ST_CLEAR;
        endcase
    end

    // Write-port muxing: clear pattern in CLEAR, queue head in RUN.
    always_comb begin
        btb_wr_en     = 1'b0;
        btb_wr_index  = '0;
        btb_wr_tag    = '0;
        btb_wr_target = '0;
        btb_wr_valid  = 1'b0;
        bht_wr_en     = 1'b0;
        bht_wr_index  = '0;
        bht_wr_taken  = 1'b0;
        bht_clr       = 1'b0;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                btb_wr_en    = 1'b1;
                btb_wr_index = clr_cnt;
                bht_wr_en    = 1'b1;
                bht_wr_index = clr_cnt;
                bht_clr      = 1'b1;
            end else if (pop) begin
                btb_wr_en     = 1'b1;
                btb_wr_index  = btb_index(head.pc);
                btb_wr_tag    = head.pc;
                btb_wr_target = head.target;
                btb_wr_valid  = 1'b1;
                bht_wr_en     = head.is_br;
                bht_wr_index  = btb_index(head.pc);
                bht_wr_taken  = head.is_br && head.taken;
            end
        end
    end

endmodule
